// File: rtl/aes_encrypt.sv
// Iterative AES encryptor: one round per clock, pre-expanded round keys.
// Optional registered done flag when AES_ENCRYPT_DONE_EN is defined.
module aes_encrypt #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [127:0]          in,
  input  logic [128*(Nr+1)-1:0] allKeys,
  output logic [127:0]          out,
  input  logic                  clk,
  input  logic                  reset
`ifdef AES_ENCRYPT_DONE_EN
  ,
  output logic                  done
`endif
);

  localparam int CW = $clog2(Nr + 2);
  localparam logic [CW-1:0] FINAL = CW'(Nr);
  localparam logic [CW-1:0] LAST  = CW'(Nr + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  if (Nk != Nr - 6) begin : g_bad_nk
    $error("aes_encrypt: Nk must equal Nr - 6");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // byte (r,c) sits at index r+4c, counted from the MSB
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [127:0]  state;
  logic [127:0]  state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] kidx;
  logic [127:0]  rkey;
  logic [127:0]  sr;
  logic [127:0]  mc;
  logic [127:0]  keys [Nr+1];

  for (genvar i = 0; i <= Nr; i++) begin : g_key
    assign keys[i] = allKeys[128*(Nr+1-i)-1 -: 128];
  end

  assign kidx = (cnt > FINAL) ? FINAL : cnt;
  assign rkey = keys[kidx];
  assign sr   = shift_rows(sub_bytes(state));
  assign mc   = mix_columns(sr);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (1'b1)
      (cnt == '0): begin
        state_nxt = in ^ rkey;
        cnt_nxt   = cnt + CW'(1);
      end
      (cnt == FINAL): begin
        state_nxt = sr ^ rkey;
        cnt_nxt   = LAST;
      end
      (cnt == LAST): begin
        state_nxt = state;
        cnt_nxt   = cnt;
      end
      default: begin
        state_nxt = mc ^ rkey;
        cnt_nxt   = cnt + CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign out = state;

`ifdef AES_ENCRYPT_DONE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (cnt_nxt == LAST);
  end
`endif

endmodule

// File: tb/tb_aes_encrypt.sv
// Bench for aes_encrypt: AES-128/192/256 instances against a byte-level
// reference model built from GF(2^8) arithmetic, plus FIPS-197 vectors.
module tb_aes_encrypt;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] E2  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [127:0] in;
  logic [127:0] pt;
  logic [1407:0] k128;
  logic [1663:0] k192;
  logic [1919:0] k256;
  logic [127:0] o128, o192, o256;
`ifdef AES_ENCRYPT_DONE_EN
  logic d128, d192, d256;
`endif

  int checks = 0;
  int fails = 0;
  int edges;
  bit cmp_on = 1'b0;

  logic [7:0]   sb [256];
  logic [127:0] rk [3][15];

  always #5 clk = ~clk;

  aes_encrypt #(.Nk(4), .Nr(10)) u128 (
    .in(in), .allKeys(k128), .out(o128), .clk(clk), .reset(reset)
`ifdef AES_ENCRYPT_DONE_EN
    , .done(d128)
`endif
  );

  aes_encrypt #(.Nk(6), .Nr(12)) u192 (
    .in(in), .allKeys(k192), .out(o192), .clk(clk), .reset(reset)
`ifdef AES_ENCRYPT_DONE_EN
    , .done(d192)
`endif
  );

  aes_encrypt #(.Nk(8), .Nr(14)) u256 (
    .in(in), .allKeys(k256), .out(o256), .clk(clk), .reset(reset)
`ifdef AES_ENCRYPT_DONE_EN
    , .done(d256)
`endif
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from the multiplicative inverse and the affine map
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // key bytes 00,01,02,... for 4*nk bytes
  task automatic expand(input int w);
    int nk = 4 + 2 * w;
    int nr = nk + 6;
    logic [31:0] ws [60];
    logic [31:0] t;
    logic [7:0] rcon = 8'h01;
    for (int i = 0; i < nk; i++)
      ws[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = ws[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      ws[i] = ws[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rk[w][r] = {ws[4*r], ws[4*r+1], ws[4*r+2], ws[4*r+3]};
  endtask

  // expected state after n edges since reset release
  function automatic logic [127:0] model(input logic [127:0] p, input int w,
                                         input int n);
    int nr = 10 + 2 * w;
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] s;
    int last;
    if (n <= 0) return 128'h0;
    s = p ^ rk[w][0];
    last = (n - 1 < nr) ? n - 1 : nr;
    for (int r = 1; r <= last; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          t[rr+4*c] = b[rr+4*((c+rr)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          b[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03)
                   ^ t[4*c+2] ^ t[4*c+3];
          b[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02)
                   ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          b[4*c+2] = t[4*c] ^ t[4*c+1]
                   ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          b[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1]
                   ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) b[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
      s = s ^ rk[w][r];
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)",
               nm, act, req, edges, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model128", o128, model(pt, 0, edges));
      check("model192", o192, model(pt, 1, edges));
      check("model256", o256, model(pt, 2, edges));
`ifdef AES_ENCRYPT_DONE_EN
      check("done128", 128'(d128), 128'(edges >= 11));
      check("done192", 128'(d192), 128'(edges >= 13));
      check("done256", 128'(d256), 128'(edges >= 15));
`endif
    end
  end

  task automatic restart(input logic [127:0] p);
    #2 reset = 1'b1;
    #1;
    check("async_rst128", o128, 128'h0);
    check("async_rst192", o192, 128'h0);
    check("async_rst256", o256, 128'h0);
    @(negedge clk);
    pt = p;
    in = p;
    reset = 1'b0;
  endtask

  initial begin
    init_sbox();
    for (int w = 0; w < 3; w++) expand(w);
    for (int i = 0; i <= 10; i++) k128[128*(11-i)-1 -: 128] = rk[0][i];
    for (int i = 0; i <= 12; i++) k192[128*(13-i)-1 -: 128] = rk[1][i];
    for (int i = 0; i <= 14; i++) k256[128*(15-i)-1 -: 128] = rk[2][i];
    pt = PT;
    in = PT;
    cmp_on = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_out", o128, 128'h0);
    reset = 1'b0;

    @(negedge clk);
    check("edge1", o128, E1);
    @(negedge clk);
    check("edge2", o128, E2);
    repeat (9) @(negedge clk);
    check("ct128", o128, C128);
    repeat (2) @(negedge clk);
    check("ct192", o192, C192);
    repeat (2) @(negedge clk);
    check("ct256", o256, C256);
    in = 128'hdeadbeef_0badf00d_cafebabe_12345678;
    repeat (16) @(negedge clk);
    check("hold128", o128, C128);
    check("hold256", o256, C256);

    // abort between edges 5 and 6, then a full rerun
    restart(PT);
    repeat (5) @(negedge clk);
    restart(PT);
    repeat (11) @(negedge clk);
    check("rerun128", o128, C128);
    repeat (4) @(negedge clk);
    check("rerun256", o256, C256);

    restart(128'hffffffff_ffffffff_ffffffff_ffffffff);
    repeat (17) @(negedge clk);
    restart({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (3) @(negedge clk);
    in = ~in;
    repeat (14) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
